// File: rtl/mips_mem_responder_pkg.sv
// Shared declarations for the MIPS memory-side blocks.
package mips_decls_p;
  typedef enum logic [1:0] {MS_IDLE, MS_WAIT, MS_RESP} mem_state_t;
  localparam int MEM_WORD_BYTES = 4;
  localparam int MEM_LAT_W      = 4;
endpackage

// File: rtl/mips_mem_responder_mem_array.sv
// Word-wide single-port RAM: combinational read, write on the clock edge.
module mem_array #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

// File: rtl/mips_mem_responder.sv
// Wait-state memory responder: one outstanding request, LATENCY cycles to a
// single-cycle response carrying read-before-write data or an error flag.
module mips_mem_responder
  import mips_decls_p::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int OFS_W = $clog2(MEM_WORD_BYTES);
  localparam logic [MEM_LAT_W-1:0] CNT_LOAD = MEM_LAT_W'(LATENCY - 1);

  mem_state_t            state, state_nx;
  logic [MEM_LAT_W-1:0]  cnt;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [31:0]           cap_wdata, rdata_q, mem_rdata;
  logic                  cap_we, cap_err, req_err, accept, mem_we;

  // Misaligned or beyond the array: rejected without touching memory.
  assign req_err = (req_addr[OFS_W-1:0] != '0) | (|req_addr[31:DEPTH_LOG2+OFS_W]);
  assign accept  = (state == MS_IDLE) && req_valid;

  always_comb begin
    state_nx = state;
    case (state)
      MS_IDLE: if (req_valid) state_nx = (LATENCY == 1) ? MS_RESP : MS_WAIT;
      MS_WAIT: if (cnt == MEM_LAT_W'(1)) state_nx = MS_RESP;
      MS_RESP: state_nx = MS_IDLE;
      default: state_nx = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MS_IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_we    <= 1'b0;
      cap_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cap_idx   <= req_addr[DEPTH_LOG2+OFS_W-1:OFS_W];
        cap_wdata <= req_wdata;
        cap_we    <= req_we;
        cap_err   <= req_err;
        cnt       <= CNT_LOAD;
      end else if (state == MS_WAIT) begin
        cnt <= cnt - MEM_LAT_W'(1);
      end
      if (state == MS_RESP) rdata_q <= rsp_rdata;
    end
  end

  // Write lands on the edge closing RESP, so the response sees the old word.
  assign mem_we = (state == MS_RESP) && cap_we && !cap_err && !reset;

  mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cap_idx),
    .wdata (cap_wdata),
    .rdata (mem_rdata)
  );

  assign req_ready = (state == MS_IDLE);
  assign rsp_valid = (state == MS_RESP);
  assign rsp_err   = rsp_valid && cap_err;
  assign rsp_rdata = rsp_valid ? (cap_err ? 32'h0 : mem_rdata) : rdata_q;
endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench: four responders at latencies 2,1,4,3 sharing clock and reset.
module tb_mips_mem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vld  [4];
  logic        we   [4];
  logic [31:0] addr [4];
  logic [31:0] wdata[4];
  logic        rdy  [4];
  logic        rvld [4];
  logic [31:0] rdata[4];
  logic        rerr [4];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 3;
    mips_mem_responder #(.DEPTH_LOG2(6), .LATENCY(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (vld[g]),
      .req_we    (we[g]),
      .req_addr  (addr[g]),
      .req_wdata (wdata[g]),
      .req_ready (rdy[g]),
      .rsp_valid (rvld[g]),
      .rsp_rdata (rdata[g]),
      .rsp_err   (rerr[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One request on instance k; lat is cycles from acceptance to rsp_valid (0 = none).
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lat, output logic rdy1);
    int n;
    @(negedge clk);
    n = 0;
    while (!rdy[k] && n < 50) begin @(negedge clk); n++; end
    vld[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    @(posedge clk); #1;
    vld[k] = 1'b0; addr[k] = 32'hFFFF_FFFF; wdata[k] = 32'h0; we[k] = ~w;
    lat = 0; rd = 32'h0; er = 1'b0; rdy1 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) rdy1 = rdy[k];
      if (rvld[k]) begin lat = c; rd = rdata[k]; er = rerr[k]; break; end
    end
  endtask

  // req_valid held high, address changing every cycle; scoreboard by acceptance.
  task automatic stream(input int k, input int l, input int nacc);
    int acc_cyc, prev_acc, nseen, nacc_done;
    logic [31:0] acc_addr;
    @(negedge clk);
    vld[k] = 1'b1; we[k] = 1'b0; addr[k] = 32'h40;
    prev_acc = -1; acc_cyc = 0; nseen = 0; nacc_done = 0; acc_addr = 32'h0;
    for (int cyc = 0; cyc < 200 && nseen < nacc; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (rvld[k]) begin
        chk($sformatf("stream%0d latency", k), 32'(cyc - acc_cyc), 32'(l));
        chk($sformatf("stream%0d rdata", k), rdata[k], 32'h1000 + {29'h0, acc_addr[4:2]});
        chk($sformatf("stream%0d err", k), {31'h0, rerr[k]}, 32'h0);
        nseen++;
      end
      if (rdy[k] && nacc_done < nacc) begin
        if (prev_acc >= 0)
          chk($sformatf("stream%0d spacing", k), 32'(cyc - prev_acc), 32'(l + 1));
        prev_acc = cyc; acc_cyc = cyc; acc_addr = addr[k]; nacc_done++;
        @(posedge clk); #1;
        if (nacc_done == nacc) vld[k] = 1'b0;
      end
      addr[k] = 32'h40 + 32'(((cyc + 1) % 8) * 4);
    end
    vld[k] = 1'b0;
    chk($sformatf("stream%0d responses", k), 32'(nseen), 32'(nacc));
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        chk_rd;
  } vec_t;

  initial begin
    vec_t vt[12];
    logic [31:0] rd;
    logic er, r1;
    int lat, nv;

    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'h0; wdata[k] = 32'h0;
    end

    vt[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
    vt[2]  = '{1'b1, 32'h10, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b1};
    vt[3]  = '{1'b0, 32'h10, 32'h0,        1'b0, 32'h12345678, 1'b1};
    vt[4]  = '{1'b1, 32'h12, 32'hCAFEF00D, 1'b1, 32'h0,        1'b1};
    vt[5]  = '{1'b0, 32'h10, 32'h0,        1'b0, 32'h12345678, 1'b1};
    vt[6]  = '{1'b0, 32'h100, 32'h0,       1'b1, 32'h0,        1'b1};
    vt[7]  = '{1'b1, 32'hFC, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
    vt[8]  = '{1'b0, 32'hFC, 32'h0,        1'b0, 32'hA5A5A5A5, 1'b1};
    vt[9]  = '{1'b0, 32'h101, 32'h0,       1'b1, 32'h0,        1'b1};
    vt[10] = '{1'b1, 32'h8000_0010, 32'h1, 1'b1, 32'h0,        1'b1};
    vt[11] = '{1'b0, 32'h10, 32'h0,        1'b0, 32'h12345678, 1'b1};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset ready", {31'h0, rdy[0]}, 32'h1);
    chk("reset rsp_valid", {31'h0, rvld[0]}, 32'h0);
    chk("reset rsp_rdata", rdata[0], 32'h0);
    chk("reset rsp_err", {31'h0, rerr[0]}, 32'h0);

    // Table on the LATENCY=2 instance
    for (int i = 0; i < 12; i++) begin
      txn(0, vt[i].w, vt[i].a, vt[i].d, rd, er, lat, r1);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d ready drop", i), {31'h0, r1}, 32'h0);
      chk($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, vt[i].exp_err});
      if (vt[i].chk_rd) chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
    end
    // Outside RESP: err low, rdata holds last response (vec11 read)
    @(negedge clk);
    chk("idle rsp_err", {31'h0, rerr[0]}, 32'h0);
    chk("idle rdata hold", rdata[0], 32'h12345678);

    // LATENCY=1: preload word 0 through a write, then read it back
    txn(1, 1'b1, 32'h0, 32'h20080005, rd, er, lat, r1);
    txn(1, 1'b0, 32'h0, 32'h0, rd, er, lat, r1);
    chk("lat1 latency", 32'(lat), 32'd1);
    chk("lat1 rdata", rd, 32'h20080005);
    for (int i = 0; i < 8; i++) txn(1, 1'b1, 32'h40 + 32'(i * 4), 32'h1000 + 32'(i), rd, er, lat, r1);
    stream(1, 1, 3);

    // LATENCY=4: reset during the second WAIT cycle drops the write
    txn(2, 1'b1, 32'h20, 32'h11112222, rd, er, lat, r1);
    chk("lat4 latency", 32'(lat), 32'd4);
    @(negedge clk);
    vld[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h55AA55AA;
    @(posedge clk); #1;
    vld[2] = 1'b0;
    @(negedge clk);
    chk("rst wait1 ready", {31'h0, rdy[2]}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst ready after", {31'h0, rdy[2]}, 32'h1);
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      if (rvld[2]) nv++;
      @(negedge clk);
    end
    chk("rst no rsp_valid", 32'(nv), 32'd0);
    txn(2, 1'b0, 32'h20, 32'h0, rd, er, lat, r1);
    chk("rst old value", rd, 32'h11112222);

    // LATENCY=3: back-to-back stream
    for (int i = 0; i < 8; i++) txn(3, 1'b1, 32'h40 + 32'(i * 4), 32'h1000 + 32'(i), rd, er, lat, r1);
    stream(3, 3, 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
Memory-side responder for the multicycle MIPS memory interface. Accepts one word-sized read or write request at a time over a valid/ready handshake, waits a programmable number of cycles, then returns a single-cycle response with read data or an error flag. It replaces the zero-wait-state unified instruction/data memory so the controller FSM can be exercised against real wait states.

Parameters:
DEPTH_LOG2, 6, log2 of memory depth in 32-bit words (default 64 words, 256 bytes)
LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present; must hold with stable fields until accepted
req_we  input  1  1 = write, 0 = read
req_addr  input  32  byte address
req_wdata  input  32  write data
req_ready  output  1  responder can accept a request this cycle
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  read data; meaningful only when rsp_valid=1
rsp_err  output  1  request rejected; meaningful only when rsp_valid=1

Behaviour:
- Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge, capture addr, we and wdata, and compute err.
  - If LATENCY=1, go to RESP. Otherwise load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0; the counter decrements each cycle.
  - Go to RESP on the edge where the counter equals 1.
  - Counter width is 4 bits.
- RESP:
  - rsp_valid=1 and req_ready=0 for exactly one cycle, then go to IDLE.
- Latency: a request accepted at the edge ending cycle T produces rsp_valid in cycle T+LATENCY. Minimum request-to-request spacing is LATENCY+1 cycles.
- Error: err=1 if captured addr[1:0]!=0, or addr[31:2] >= 2**DEPTH_LOG2.
  - On error: no write is performed, rsp_rdata=0, rsp_err=1.
- Read (no error): rsp_rdata = mem[addr[DEPTH_LOG2+1:2]], sampled combinationally from the array during RESP. rsp_err=0.
- Write (no error):
  - The array is written on the edge ending the RESP cycle.
  - rsp_rdata = the old word (read-before-write).
  - rsp_err=0.
- Outputs outside RESP: rsp_valid=0, rsp_err=0, rsp_rdata holds its last registered value.
- Request-field changes after acceptance have no effect; all fields come from the captured copy.
- req_valid=0 in IDLE: remain in IDLE with no side effects.
- Reset mid-operation (WAIT or RESP): pending request is dropped, no write occurs, return to IDLE next cycle.
- Illegal state encoding: go to IDLE.

Decomposition:
- mips_decls_p gains:
  - mem_state_t enum {MS_IDLE, MS_WAIT, MS_RESP}
  - MEM_WORD_BYTES=4
  - MEM_LAT_W=4
- Sub-module mem_array: DEPTH_LOG2-parameterised single-port RAM with combinational read and write on the clock edge when we=1, optionally preloaded by $readmemh.
- mips_mem_responder contains the FSM, capture registers, counter and error check.

Test Plan:
1. Reset, then write req addr=0x10, wdata=0xDEADBEEF, LATENCY=2 -> req_ready drops the cycle after acceptance; rsp_valid high exactly 2 cycles after acceptance, rsp_err=0; a following read of 0x10 returns 0xDEADBEEF.
2. LATENCY=1, read addr=0x0 after preload 0x20080005 -> rsp_valid in the cycle after acceptance, rsp_rdata=0x20080005; next request is accepted 2 cycles after the first.
3. Misaligned write addr=0x12, then read 0x10 -> write response has rsp_err=1, rsp_rdata=0; read returns the prior contents, unchanged.
4. Out-of-range read addr=0x100 (DEPTH_LOG2=6) -> rsp_err=1, rsp_rdata=0; read addr=0xFC -> rsp_err=0.
5. Write 0x55AA55AA to 0x20 with LATENCY=4, reset asserted in the second WAIT cycle -> no rsp_valid, req_ready=1 the cycle after reset, a read of 0x20 returns the old value.
6. req_valid held high continuously with changing addr, LATENCY=3 -> exactly one acceptance per 4 cycles; each response matches the address captured at its acceptance.
